// File: rtl/ir_player_ctrl_pkg.sv
// Shared definitions for the IR player: controller states, command codes and key
// bit positions. The display and audio blocks import this package as well.
package ir_player_ctrl_pkg;

   localparam int DIGIT_W  = 4;
   localparam int NUM_KEYS = 15;

   // Bit positions in the conditioned key vector {vol+, vol-, play, next, prev, digits[9:0]}
   localparam int K_PREV = 10;
   localparam int K_NEXT = 11;
   localparam int K_PLAY = 12;
   localparam int K_VDN  = 13;
   localparam int K_VUP  = 14;

   typedef enum logic [1:0] {
      ST_STOP  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_PAUSE = 2'd2,
      ST_ENTRY = 2'd3
   } state_t;

   typedef enum logic [2:0] {
      CMD_NONE  = 3'd0,
      CMD_PLAY  = 3'd1,
      CMD_PREV  = 3'd2,
      CMD_NEXT  = 3'd3,
      CMD_VUP   = 3'd4,
      CMD_VDN   = 3'd5,
      CMD_DIGIT = 3'd6
   } cmd_t;

endpackage

// File: rtl/ir_cmd_cond.sv
// Key conditioning: two-stage register, rising-edge detect and a fixed-priority
// encoder that yields at most one command per cycle.
// Optional macro AUTO_REPEAT_EN adds hold-to-repeat for the volume keys.
module ir_cmd_cond
   import ir_player_ctrl_pkg::*;
#(
   parameter int HOLD_DELAY    = 25_000_000,
   parameter int REPEAT_PERIOD = 10_000_000
) (
   input  logic               clk,
   input  logic               reset,
   input  logic [9:0]         botao,
   input  logic               prev,
   input  logic               next,
   input  logic               play,
   input  logic [1:0]         vol,
   output logic               cmd_valid,
   output cmd_t               cmd_code,
   output logic [DIGIT_W-1:0] cmd_digit
);

   logic [NUM_KEYS-1:0] keys_in, k_q, k_q2, press;

   assign keys_in = {vol, play, next, prev, botao};
   assign press   = k_q & ~k_q2;

   // Key history. Reset loads both stages with the live levels so a key held
   // through reset is not seen as a fresh press afterwards.
   always_ff @(posedge clk) begin
      if (reset) begin
         k_q  <= keys_in;
         k_q2 <= keys_in;
      end else begin
         k_q  <= keys_in;
         k_q2 <= k_q;
      end
   end

`ifdef AUTO_REPEAT_EN
   localparam int RMAX = (HOLD_DELAY > REPEAT_PERIOD) ? HOLD_DELAY : REPEAT_PERIOD;
   localparam int RW   = $clog2(RMAX + 1);

   logic          rep_act, rep_up, rep_ph, rep_held, rep_fire;
   logic [RW-1:0] rep_cnt;

   assign rep_held = rep_up ? k_q[K_VUP] : k_q[K_VDN];
   assign rep_fire = rep_act && rep_held &&
                     (rep_ph ? (rep_cnt == RW'(REPEAT_PERIOD)) : (rep_cnt == RW'(HOLD_DELAY)));

   // Hold timer: armed by a vol command, restarted by any press, dropped on release.
   // rep_cnt equals the number of cycles since the press (or since the last repeat).
   always_ff @(posedge clk) begin
      if (reset) begin
         rep_act <= 1'b0;
         rep_up  <= 1'b0;
         rep_ph  <= 1'b0;
         rep_cnt <= '0;
      end else if (|press) begin
         rep_act <= cmd_valid && (cmd_code == CMD_VUP || cmd_code == CMD_VDN);
         rep_up  <= (cmd_code == CMD_VUP);
         rep_ph  <= 1'b0;
         rep_cnt <= RW'(1);
      end else if (rep_act && !rep_held) begin
         rep_act <= 1'b0;
      end else if (rep_act) begin
         if (rep_fire) begin
            rep_ph  <= 1'b1;
            rep_cnt <= RW'(1);
         end else begin
            rep_cnt <= rep_cnt + 1'b1;
         end
      end
   end
`else
   // Repeat timing parameters only matter when auto-repeat is built.
   logic unused_rep_cfg;
   assign unused_rep_cfg = (HOLD_DELAY == REPEAT_PERIOD);
`endif

   // Priority: play > prev > next > vol+ > vol- > lowest digit; the rest are dropped.
   always_comb begin
      cmd_valid = 1'b0;
      cmd_code  = CMD_NONE;
      cmd_digit = '0;
      if (press[K_PLAY]) begin
         cmd_valid = 1'b1;
         cmd_code  = CMD_PLAY;
      end else if (press[K_PREV]) begin
         cmd_valid = 1'b1;
         cmd_code  = CMD_PREV;
      end else if (press[K_NEXT]) begin
         cmd_valid = 1'b1;
         cmd_code  = CMD_NEXT;
      end else if (press[K_VUP]) begin
         cmd_valid = 1'b1;
         cmd_code  = CMD_VUP;
      end else if (press[K_VDN]) begin
         cmd_valid = 1'b1;
         cmd_code  = CMD_VDN;
      end else if (|press[9:0]) begin
         cmd_valid = 1'b1;
         cmd_code  = CMD_DIGIT;
         for (int i = 9; i >= 0; i--)
            if (press[i]) cmd_digit = DIGIT_W'(i);
      end
`ifdef AUTO_REPEAT_EN
      else if (rep_fire) begin
         cmd_valid = 1'b1;
         cmd_code  = rep_up ? CMD_VUP : CMD_VDN;
      end
`endif
   end

endmodule

// File: rtl/ir_player_ctrl.sv
// Transport/volume controller: STOP/PLAY/PAUSE/ENTRY state machine, track index,
// volume level and two-digit track entry with timeout.
// Optional macro AUTO_REPEAT_EN (in ir_cmd_cond) enables vol key auto-repeat.
module ir_player_ctrl
   import ir_player_ctrl_pkg::*;
#(
   parameter int NUM_TRACKS    = 16,
   parameter int VOL_MAX       = 15,
   parameter int VOL_RESET     = 8,
   parameter int ENTRY_TIMEOUT = 50_000_000,
   parameter int HOLD_DELAY    = 25_000_000,
   parameter int REPEAT_PERIOD = 10_000_000,
   localparam int TW = (NUM_TRACKS > 1) ? $clog2(NUM_TRACKS) : 1
) (
   input  logic          clk,
   input  logic          reset,
   input  logic [9:0]    botao,
   input  logic          prev,
   input  logic          next,
   input  logic          play,
   input  logic [1:0]    vol,
   output logic [TW-1:0] track,
   output logic [3:0]    vol_level,
   output logic          playing,
   output logic          paused,
   output logic          entry_active,
   output logic [6:0]    entry_value,
   output logic          track_start,
   output logic          entry_err
);

   localparam int TMW = $clog2(ENTRY_TIMEOUT + 1);

   logic               cmd_valid;
   cmd_t               cmd_code;
   logic [DIGIT_W-1:0] cmd_digit;

   state_t         state, state_nx, ret, ret_nx;
   logic [TW-1:0]  track_nx, trk_inc, trk_dec;
   logic [3:0]     vol_nx;
   logic [6:0]     acc, acc_nx, commit_val;
   logic [TMW-1:0] tmr, tmr_nx;
   logic           ts_nx, err_nx, do_commit;

   ir_cmd_cond #(
      .HOLD_DELAY    (HOLD_DELAY),
      .REPEAT_PERIOD (REPEAT_PERIOD)
   ) u_cond (
      .clk       (clk),
      .reset     (reset),
      .botao     (botao),
      .prev      (prev),
      .next      (next),
      .play      (play),
      .vol       (vol),
      .cmd_valid (cmd_valid),
      .cmd_code  (cmd_code),
      .cmd_digit (cmd_digit)
   );

   assign trk_inc = (track == TW'(NUM_TRACKS - 1)) ? '0 : track + 1'b1;
   assign trk_dec = (track == '0) ? TW'(NUM_TRACKS - 1) : track - 1'b1;

   // State and datapath registers; pulses are registered so they last one cycle.
   always_ff @(posedge clk) begin
      if (reset) begin
         state       <= ST_STOP;
         ret         <= ST_STOP;
         track       <= '0;
         vol_level   <= 4'(VOL_RESET);
         acc         <= '0;
         tmr         <= '0;
         track_start <= 1'b0;
         entry_err   <= 1'b0;
      end else begin
         state       <= state_nx;
         ret         <= ret_nx;
         track       <= track_nx;
         vol_level   <= vol_nx;
         acc         <= acc_nx;
         tmr         <= tmr_nx;
         track_start <= ts_nx;
         entry_err   <= err_nx;
      end
   end

   // Next state: transport commands, entry accumulation/commit/abort, volume in any state.
   always_comb begin
      state_nx   = state;
      ret_nx     = ret;
      track_nx   = track;
      vol_nx     = vol_level;
      acc_nx     = acc;
      tmr_nx     = tmr;
      ts_nx      = 1'b0;
      err_nx     = 1'b0;
      do_commit  = 1'b0;
      commit_val = acc;

      if (cmd_valid && cmd_code == CMD_VUP && vol_level < 4'(VOL_MAX)) vol_nx = vol_level + 1'b1;
      if (cmd_valid && cmd_code == CMD_VDN && vol_level != 4'd0)       vol_nx = vol_level - 1'b1;

      if (state == ST_ENTRY) begin
         tmr_nx = tmr + 1'b1;
         if (cmd_valid && cmd_code == CMD_DIGIT) begin
            do_commit  = 1'b1;
            commit_val = acc * 7'd10 + 7'(cmd_digit);
         end else if (cmd_valid && cmd_code == CMD_PLAY) begin
            do_commit = 1'b1;
         end else if (cmd_valid && (cmd_code == CMD_PREV || cmd_code == CMD_NEXT)) begin
            state_nx = ret;
            acc_nx   = '0;
         end else if (tmr == TMW'(ENTRY_TIMEOUT - 1)) begin
            do_commit = 1'b1;
         end
      end else if (cmd_valid) begin
         case (cmd_code)
            CMD_PLAY: begin
               state_nx = (state == ST_PLAY) ? ST_PAUSE : ST_PLAY;
               ts_nx    = (state == ST_STOP);
            end
            CMD_PREV: begin
               track_nx = trk_dec;
               ts_nx    = (state == ST_PLAY);
            end
            CMD_NEXT: begin
               track_nx = trk_inc;
               ts_nx    = (state == ST_PLAY);
            end
            CMD_DIGIT: begin
               ret_nx   = state;
               acc_nx   = 7'(cmd_digit);
               tmr_nx   = '0;
               state_nx = ST_ENTRY;
            end
            default: ;
         endcase
      end

      if (do_commit) begin
         acc_nx = '0;
         if (32'(commit_val) < NUM_TRACKS) begin
            track_nx = TW'(commit_val);
            state_nx = ST_PLAY;
            ts_nx    = 1'b1;
         end else begin
            err_nx   = 1'b1;
            state_nx = ret;
         end
      end
   end

   // Status outputs decoded from the state.
   always_comb begin
      playing      = (state == ST_PLAY);
      paused       = (state == ST_PAUSE);
      entry_active = (state == ST_ENTRY);
      entry_value  = (state == ST_ENTRY) ? acc : 7'd0;
   end

endmodule

// File: tb/tb_ir_player_ctrl.sv
// Directed bench for ir_player_ctrl. Pulses (track_start / entry_err) are checked
// against a queue of expected events pushed when the causing key is driven.
module tb_ir_player_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [14:0] keys;
   logic [3:0]  track;
   logic [3:0]  vol_level;
   logic        playing, paused, entry_active, track_start, entry_err;
   logic [6:0]  entry_value;

   int total = 0;
   int bad   = 0;

   typedef struct {
      bit err;
      int trk;
   } ev_t;
   ev_t exp_q[$];

   always #5 clk = ~clk;

   ir_player_ctrl #(
      .NUM_TRACKS    (16),
      .VOL_MAX       (15),
      .VOL_RESET     (8),
      .ENTRY_TIMEOUT (100),
      .HOLD_DELAY    (20),
      .REPEAT_PERIOD (5)
   ) dut (
      .clk          (clk),
      .reset        (reset),
      .botao        (keys[9:0]),
      .prev         (keys[10]),
      .next         (keys[11]),
      .play         (keys[12]),
      .vol          (keys[14:13]),
      .track        (track),
      .vol_level    (vol_level),
      .playing      (playing),
      .paused       (paused),
      .entry_active (entry_active),
      .entry_value  (entry_value),
      .track_start  (track_start),
      .entry_err    (entry_err)
   );

   task automatic chk(input string tag, input int obs, input int exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   // One-cycle key tap, then let the command take effect.
   task automatic tap(input int id);
      keys[id] = 1'b1;
      tick(1);
      keys[id] = 1'b0;
      tick(2);
   endtask

   // Scoreboard side: every pulse must match the oldest expected event.
   always @(negedge clk) begin
      if (!reset && (track_start || entry_err)) begin
         chk("pulse_excl", int'(track_start & entry_err), 0);
         if (exp_q.size() == 0) begin
            total++;
            bad++;
            $error("FAIL unexpected_pulse: observed start=%0d err=%0d expected none",
                   track_start, entry_err);
         end else begin
            ev_t e;
            e = exp_q.pop_front();
            chk("pulse_kind", int'(entry_err), int'(e.err));
            if (!e.err) chk("pulse_track", int'(track), e.trk);
         end
      end
   end

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   initial begin
      keys  = '0;
      reset = 1'b1;
      tick(3);
      chk("rst_track", track, 0);
      chk("rst_vol", vol_level, 8);
      chk("rst_playing", playing, 0);
      chk("rst_paused", paused, 0);
      chk("rst_entry", entry_active, 0);
      chk("rst_entry_val", entry_value, 0);
      chk("rst_start", track_start, 0);
      chk("rst_err", entry_err, 0);
      reset = 1'b0;
      tick(1);

      // Volume saturation in STOP
      for (int i = 1; i <= 10; i++) begin
         tap(14);
         chk("vol_up", vol_level, (8 + i > 15) ? 15 : 8 + i);
      end
      for (int i = 1; i <= 20; i++) begin
         tap(13);
         chk("vol_dn", vol_level, (15 - i < 0) ? 0 : 15 - i);
      end

      // Play held 3 cycles: one pulse, two edges after the rise
      exp_q.push_back('{1'b0, 0});
      keys[12] = 1'b1;
      tick(1);
      chk("play_lat1", track_start, 0);
      tick(1);
      chk("play_lat2", track_start, 1);
      chk("play_playing", playing, 1);
      tick(1);
      chk("play_lat3", track_start, 0);
      keys[12] = 1'b0;
      tick(2);
      chk("play_track", track, 0);
      tap(12);
      chk("pause", paused, 1);
      chk("pause_np", playing, 0);

      // PAUSE: prev wraps without a pulse; play resumes without a pulse
      tap(10);
      chk("pause_prev_trk", track, 15);
      chk("pause_prev_st", paused, 1);
      tap(12);
      chk("resume", playing, 1);

      // PLAY wrap with pulses
      exp_q.push_back('{1'b0, 0});
      tap(11);
      chk("next_wrap", track, 0);
      exp_q.push_back('{1'b0, 15});
      tap(10);
      chk("prev_wrap", track, 15);

      // Entry 1,2 -> track 12
      tap(1);
      chk("ent1_active", entry_active, 1);
      chk("ent1_val", entry_value, 1);
      chk("ent1_trk", track, 15);
      exp_q.push_back('{1'b0, 12});
      tap(2);
      chk("ent12_trk", track, 12);
      chk("ent12_play", playing, 1);
      chk("ent12_done", entry_active, 0);
      chk("ent12_val", entry_value, 0);

      // Entry 2,0 -> rejected, back to PLAY
      tap(2);
      chk("ent2_val", entry_value, 2);
      exp_q.push_back('{1'b1, 0});
      tap(0);
      chk("ent20_done", entry_active, 0);
      chk("ent20_ret", playing, 1);
      chk("ent20_trk", track, 12);

      // Entry 9,9 from PAUSE -> rejected, back to PAUSE
      tap(12);
      tap(9);
      exp_q.push_back('{1'b1, 0});
      tap(9);
      chk("ent99_ret", paused, 1);
      chk("ent99_trk", track, 12);
      tap(12);

      // Timeout commit after 100 ENTRY cycles
      exp_q.push_back('{1'b0, 3});
      keys[3] = 1'b1;
      tick(1);
      keys[3] = 1'b0;
      tick(1);
      chk("to_enter", entry_active, 1);
      tick(99);
      chk("to_wait", entry_active, 1);
      tick(1);
      chk("to_commit", entry_active, 0);
      chk("to_trk", track, 3);
      chk("to_play", playing, 1);

      // Digit then next: abort, key consumed
      tap(6);
      tap(11);
      chk("abort_done", entry_active, 0);
      chk("abort_trk", track, 3);
      chk("abort_ret", playing, 1);

      // vol+ and digit 5 together: only the vol step
      keys[14] = 1'b1;
      keys[5]  = 1'b1;
      tick(1);
      keys[14] = 1'b0;
      keys[5]  = 1'b0;
      tick(2);
      chk("prio_vol", vol_level, 1);
      chk("prio_noent", entry_active, 0);

      // Reset mid-ENTRY with play held across it
      tap(7);
      chk("pre_rst_entry", entry_active, 1);
      keys[12] = 1'b1;
      reset    = 1'b1;
      tick(2);
      reset = 1'b0;
      tick(3);
      chk("mid_rst_entry", entry_active, 0);
      chk("mid_rst_vol", vol_level, 8);
      chk("mid_rst_trk", track, 0);
      chk("held_play_ignored", playing, 0);
      keys[12] = 1'b0;
      tick(2);

      // vol+ held 40 cycles
      keys[14] = 1'b1;
      tick(40);
      keys[14] = 1'b0;
      tick(3);
`ifdef AUTO_REPEAT_EN
      chk("hold_vol", vol_level, 13);
`else
      chk("hold_vol", vol_level, 9);
`endif

      tick(2);
      chk("queue_empty", exp_q.size(), 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
